csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every CSR and data port.
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0000_0000, mtvec value after reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 csr_wbk_v_i  in  1  CSR write strobe from exe writeback.
REQ-006 csr_adr_i  in  12  CSR write address.
REQ-007 csr_data_i  in  XLEN  CSR write data.
REQ-008 exception_i  in  1  trap taken this cycle.
REQ-009 mcause_i / mtval_i / mepc_i  in  XLEN each  trap cause, trap value, faulting PC.
REQ-010 mret_i  in  1  mret retiring this cycle.
REQ-011 retire_i  in  1  one instruction retired this cycle.
REQ-012 csr_rd_adr_i  in  12  decode-stage read address.
REQ-013 csr_rd_data_o  out  XLEN  combinational read data.
REQ-014 csr_rd_illegal_o  out  1  read address unimplemented.
REQ-015 mepc_q_o / mtvec_q_o / mstatus_q_o  out  XLEN each  registered CSR values to exe.

Function
REQ-016 Implemented CSRs SHALL be: mstatus 0x300 (MIE bit3, MPIE bit7, MPP bits12:11 only; others read 0), misa 0x301 RO 32'h4000_0100, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 RO 0, mhartid 0xF14 RO 0.
REQ-017 Read SHALL be combinational and return pre-write value when read and write hit same address same cycle (no bypass; exe forwards).
REQ-018 Unimplemented read address SHALL return 0 and assert csr_rd_illegal_o same cycle.
REQ-019 Writes to RO or unimplemented addresses SHALL be silently dropped.
REQ-020 mtvec and mepc writes SHALL force bits[1:0] to 0 (direct mode, aligned PC).
REQ-021 On exception_i, next edge: mepc<=mepc_i&~3, mcause<=mcause_i, mtval<=mtval_i, MPIE<=MIE, MIE<=0, MPP<=2'b11.
REQ-022 On mret_i, next edge: MIE<=MPIE, MPIE<=1, MPP<=2'b00.
REQ-023 Priority: exception_i > mret_i > csr_wbk_v_i for any overlapping field; non-overlapping CSR writes in the same cycle still commit except when exception_i (all CSR writes dropped).
REQ-024 Outputs mepc_q_o, mtvec_q_o, mstatus_q_o SHALL reflect state one cycle after update (registered, zero combinational path from inputs).

Reset
REQ-025 On reset high at an edge: mstatus=0x0000_1800 (MPP=11), mtvec=MTVEC_RST, all other RW CSRs and counters=0.
REQ-026 Reset SHALL override every simultaneous exception, mret, write, increment.
REQ-027 csr_rd_data_o during reset SHALL reflect reset values from the cycle after the first reset edge.

Configuration
REQ-028 Macro CSR_COUNTERS_EN defined: 64-bit mcycle (0xB00 low, 0xB80 high) incrementing every non-reset cycle, 64-bit minstret (0xB02, 0xB82) incrementing when retire_i=1, both RW.
REQ-029 With CSR_COUNTERS_EN: write to a half replaces that half only, the write wins over that cycle's increment, no carry into the other half from the written value; wrap 2^64-1 -> 0.
REQ-030 Without CSR_COUNTERS_EN: no counter flops; 0xB00/0xB80/0xB02/0xB82 are unimplemented per REQ-018/REQ-019.

Verification
REQ-031 Write 0x305 data 0x8000_0103 -> next cycle mtvec_q_o=0x8000_0100; read 0x305 same write cycle returns old value.
REQ-032 MIE=1, exception_i with mepc_i=0x1006, mcause_i=2, plus csr write 0x341=0xFFFF -> mepc_q_o=0x1004, mcause=2, mstatus_q_o=0x1880.
REQ-033 After REQ-032, mret_i -> mstatus_q_o=0x0088 (MIE=1, MPIE=1, MPP=00).
REQ-034 Read 0x7C0 -> csr_rd_data_o=0, csr_rd_illegal_o=1; write 0x301=0xFFFF_FFFF -> misa still 0x4000_0100.
REQ-035 CSR_COUNTERS_EN: write 0xB00=0xFFFF_FFFE, 0xB80=0 -> two cycles later mcycle={1,0x0000_0000}; minstret counts only retire_i cycles; without macro read 0xB00 illegal.
REQ-036 Assert reset mid-trap (exception_i=1 same cycle) -> mepc=0, mcause=0, mstatus=0x1800, mtvec=MTVEC_RST.

Source files
------------

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : Machine-mode CSR file with trap entry/return and a combinational
//            read port. Optional mcycle/minstret counters when the macro
//            CSR_COUNTERS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_wbk_v_i,
    input  logic [11:0]     csr_adr_i,
    input  logic [XLEN-1:0] csr_data_i,
    input  logic            exception_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] mtval_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic [11:0]     csr_rd_adr_i,
    output logic [XLEN-1:0] csr_rd_data_o,
    output logic            csr_rd_illegal_o,
    output logic [XLEN-1:0] mepc_q_o,
    output logic [XLEN-1:0] mtvec_q_o,
    output logic [XLEN-1:0] mstatus_q_o
);

    localparam logic [11:0] c_ADR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_ADR_MISA     = 12'h301;
    localparam logic [11:0] c_ADR_MIE      = 12'h304;
    localparam logic [11:0] c_ADR_MTVEC    = 12'h305;
    localparam logic [11:0] c_ADR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_ADR_MEPC     = 12'h341;
    localparam logic [11:0] c_ADR_MCAUSE   = 12'h342;
    localparam logic [11:0] c_ADR_MTVAL    = 12'h343;
    localparam logic [11:0] c_ADR_MIP      = 12'h344;
    localparam logic [11:0] c_ADR_MHARTID  = 12'hF14;
    localparam logic [11:0] c_ADR_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_ADR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] c_ADR_MINSTR   = 12'hB02;
    localparam logic [11:0] c_ADR_MINSTRH  = 12'hB82;

    localparam logic [31:0]     c_MISA       = 32'h4000_0100;
    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [1:0]      r_mstatus_mpp;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic [XLEN-1:0] w_mstatus;
    logic            w_wr;

    assign w_mstatus = XLEN'({19'b0, r_mstatus_mpp, 3'b0, r_mstatus_mpie,
                              3'b0, r_mstatus_mie, 3'b0});

    // A trap squashes the instruction in writeback, so its CSR write is lost.
    assign w_wr = csr_wbk_v_i & ~exception_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mstatus_mpp  <= 2'b11;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else begin
            if (exception_i) begin
                r_mepc         <= mepc_i & c_ALIGN_MASK;
                r_mcause       <= mcause_i;
                r_mtval        <= mtval_i;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mstatus_mpp  <= 2'b11;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
                r_mstatus_mpp  <= 2'b00;
            end

            if (w_wr) begin
                case (csr_adr_i)
                    c_ADR_MSTATUS: begin
                        // Every writable mstatus field is also owned by mret.
                        if (!mret_i) begin
                            r_mstatus_mie  <= csr_data_i[3];
                            r_mstatus_mpie <= csr_data_i[7];
                            r_mstatus_mpp  <= csr_data_i[12:11];
                        end
                    end
                    c_ADR_MIE:      r_mie      <= csr_data_i;
                    c_ADR_MTVEC:    r_mtvec    <= csr_data_i & c_ALIGN_MASK;
                    c_ADR_MSCRATCH: r_mscratch <= csr_data_i;
                    c_ADR_MEPC:     r_mepc     <= csr_data_i & c_ALIGN_MASK;
                    c_ADR_MCAUSE:   r_mcause   <= csr_data_i;
                    c_ADR_MTVAL:    r_mtval    <= csr_data_i;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic [63:0] w_mcycle_inc;
    logic [63:0] w_minstret_inc;

    assign w_mcycle_inc   = r_mcycle + 64'd1;
    assign w_minstret_inc = r_minstret + {63'd0, retire_i};

    // A low-half write freezes the high half (no carry); a high-half write
    // lets the low half keep counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wr && csr_adr_i == c_ADR_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], csr_data_i[31:0]};
            else if (w_wr && csr_adr_i == c_ADR_MCYCLEH)
                r_mcycle <= {csr_data_i[31:0], w_mcycle_inc[31:0]};
            else
                r_mcycle <= w_mcycle_inc;

            if (w_wr && csr_adr_i == c_ADR_MINSTR)
                r_minstret <= {r_minstret[63:32], csr_data_i[31:0]};
            else if (w_wr && csr_adr_i == c_ADR_MINSTRH)
                r_minstret <= {csr_data_i[31:0], w_minstret_inc[31:0]};
            else
                r_minstret <= w_minstret_inc;
        end
    end
`else
    logic w_unused_retire;
    assign w_unused_retire = retire_i;
`endif

    always_comb begin
        csr_rd_data_o    = '0;
        csr_rd_illegal_o = 1'b0;
        case (csr_rd_adr_i)
            c_ADR_MSTATUS:  csr_rd_data_o = w_mstatus;
            c_ADR_MISA:     csr_rd_data_o = XLEN'(c_MISA);
            c_ADR_MIE:      csr_rd_data_o = r_mie;
            c_ADR_MTVEC:    csr_rd_data_o = r_mtvec;
            c_ADR_MSCRATCH: csr_rd_data_o = r_mscratch;
            c_ADR_MEPC:     csr_rd_data_o = r_mepc;
            c_ADR_MCAUSE:   csr_rd_data_o = r_mcause;
            c_ADR_MTVAL:    csr_rd_data_o = r_mtval;
            c_ADR_MIP:      csr_rd_data_o = '0;
            c_ADR_MHARTID:  csr_rd_data_o = '0;
`ifdef CSR_COUNTERS_EN
            c_ADR_MCYCLE:   csr_rd_data_o = XLEN'(r_mcycle[31:0]);
            c_ADR_MCYCLEH:  csr_rd_data_o = XLEN'(r_mcycle[63:32]);
            c_ADR_MINSTR:   csr_rd_data_o = XLEN'(r_minstret[31:0]);
            c_ADR_MINSTRH:  csr_rd_data_o = XLEN'(r_minstret[63:32]);
`endif
            default:        csr_rd_illegal_o = 1'b1;
        endcase
    end

    assign mepc_q_o    = r_mepc;
    assign mtvec_q_o   = r_mtvec;
    assign mstatus_q_o = w_mstatus;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Directed vector table plus reset/counter sequences for csr_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] c_MT = 32'h2000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_wbk_v_i;
    logic [11:0] csr_adr_i;
    logic [31:0] csr_data_i;
    logic        exception_i;
    logic [31:0] mcause_i, mtval_i, mepc_i;
    logic        mret_i;
    logic        retire_i;
    logic [11:0] csr_rd_adr_i;
    logic [31:0] csr_rd_data_o;
    logic        csr_rd_illegal_o;
    logic [31:0] mepc_q_o, mtvec_q_o, mstatus_q_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_file #(.XLEN(32), .MTVEC_RST(c_MT)) dut (
        .clk              (clk),
        .reset            (reset),
        .csr_wbk_v_i      (csr_wbk_v_i),
        .csr_adr_i        (csr_adr_i),
        .csr_data_i       (csr_data_i),
        .exception_i      (exception_i),
        .mcause_i         (mcause_i),
        .mtval_i          (mtval_i),
        .mepc_i           (mepc_i),
        .mret_i           (mret_i),
        .retire_i         (retire_i),
        .csr_rd_adr_i     (csr_rd_adr_i),
        .csr_rd_data_o    (csr_rd_data_o),
        .csr_rd_illegal_o (csr_rd_illegal_o),
        .mepc_q_o         (mepc_q_o),
        .mtvec_q_o        (mtvec_q_o),
        .mstatus_q_o      (mstatus_q_o)
    );

    typedef struct {
        logic        wbk;
        logic [11:0] adr;
        logic [31:0] data;
        logic        exc;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] epc;
        logic        mret;
        logic [11:0] rd_adr;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic [31:0] exp_mepc;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_mstatus;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        csr_wbk_v_i  = 1'b0;
        csr_adr_i    = '0;
        csr_data_i   = '0;
        exception_i  = 1'b0;
        mcause_i     = '0;
        mtval_i      = '0;
        mepc_i       = '0;
        mret_i       = 1'b0;
        retire_i     = 1'b0;
        csr_rd_adr_i = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        idle();
        csr_wbk_v_i = 1'b1;
        csr_adr_i   = a;
        csr_data_i  = d;
    endtask

    task automatic rd_check(input string name, input logic [11:0] a,
                            input logic [31:0] exp_d, input logic exp_i);
        csr_rd_adr_i = a;
        #1;
        check({name, "_data"}, csr_rd_data_o, exp_d);
        check({name, "_illegal"}, {31'd0, csr_rd_illegal_o}, {31'd0, exp_i});
    endtask

    initial begin
        // wbk adr data | exc cause tval epc | mret | rd_adr exp_rd ill | mepc mtvec mstatus
        vecs[0]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h300, 32'h1800,     1'b0, 32'h0,    c_MT,         32'h1800};
        vecs[1]  = '{1'b1, 12'h305, 32'h8000_0103,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h305, c_MT,         1'b0, 32'h0,    32'h8000_0100, 32'h1800};
        vecs[2]  = '{1'b1, 12'h300, 32'hFFFF_FFFF,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h305, 32'h8000_0100, 1'b0, 32'h0,    32'h8000_0100, 32'h1888};
        vecs[3]  = '{1'b1, 12'h300, 32'h0000_0008,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h300, 32'h1888,     1'b0, 32'h0,    32'h8000_0100, 32'h0008};
        vecs[4]  = '{1'b1, 12'h341, 32'h0000_FFFF,  1'b1, 32'h2, 32'hDEAD,  32'h1006, 1'b0, 12'h7C0, 32'h0,        1'b1, 32'h1004, 32'h8000_0100, 32'h1880};
        vecs[5]  = '{1'b1, 12'h301, 32'hFFFF_FFFF,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h342, 32'h2,        1'b0, 32'h1004, 32'h8000_0100, 32'h1880};
        vecs[6]  = '{1'b1, 12'h340, 32'h1234_5678,  1'b0, 32'h0, 32'h0,     32'h0,    1'b1, 12'h301, 32'h4000_0100, 1'b0, 32'h1004, 32'h8000_0100, 32'h0088};
        vecs[7]  = '{1'b1, 12'h341, 32'h0000_2003,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h340, 32'h1234_5678, 1'b0, 32'h2000, 32'h8000_0100, 32'h0088};
        vecs[8]  = '{1'b1, 12'h300, 32'h0000_1800,  1'b0, 32'h0, 32'h0,     32'h0,    1'b1, 12'h343, 32'hDEAD,     1'b0, 32'h2000, 32'h8000_0100, 32'h0088};
        vecs[9]  = '{1'b1, 12'h304, 32'h0000_0888,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'hF14, 32'h0,        1'b0, 32'h2000, 32'h8000_0100, 32'h0088};
        vecs[10] = '{1'b1, 12'h344, 32'h0000_0005,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h304, 32'h888,      1'b0, 32'h2000, 32'h8000_0100, 32'h0088};
        vecs[11] = '{1'b1, 12'h342, 32'h0000_0007,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h344, 32'h0,        1'b0, 32'h2000, 32'h8000_0100, 32'h0088};
        vecs[12] = '{1'b0, 12'h000, 32'h0,          1'b1, 32'hB, 32'h0,     32'h3000, 1'b1, 12'h342, 32'h7,        1'b0, 32'h3000, 32'h8000_0100, 32'h1880};
        vecs[13] = '{1'b1, 12'h305, 32'hFFFF_FFFF,  1'b0, 32'h0, 32'h0,     32'h0,    1'b0, 12'h341, 32'h3000,     1'b0, 32'h3000, 32'hFFFF_FFFC, 32'h1880};
        vecs[14] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0, 32'h0,     32'h0,    1'b1, 12'h300, 32'h1880,     1'b0, 32'h3000, 32'hFFFF_FFFC, 32'h0088};

        idle();
        reset = 1'b1;
        csr_rd_adr_i = 12'h305;
        @(posedge clk);
        #1;
        check("rst_rd_mtvec", csr_rd_data_o, c_MT);
        check("rst_mstatus", mstatus_q_o, 32'h1800);
        check("rst_mepc", mepc_q_o, 32'h0);
        check("rst_mtvec", mtvec_q_o, c_MT);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            csr_wbk_v_i  = vecs[i].wbk;
            csr_adr_i    = vecs[i].adr;
            csr_data_i   = vecs[i].data;
            exception_i  = vecs[i].exc;
            mcause_i     = vecs[i].cause;
            mtval_i      = vecs[i].tval;
            mepc_i       = vecs[i].epc;
            mret_i       = vecs[i].mret;
            csr_rd_adr_i = vecs[i].rd_adr;
            #1;
            check($sformatf("v%0d_rd", i), csr_rd_data_o, vecs[i].exp_rd);
            check($sformatf("v%0d_ill", i), {31'd0, csr_rd_illegal_o}, {31'd0, vecs[i].exp_ill});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mepc", i), mepc_q_o, vecs[i].exp_mepc);
            check($sformatf("v%0d_mtvec", i), mtvec_q_o, vecs[i].exp_mtvec);
            check($sformatf("v%0d_mstatus", i), mstatus_q_o, vecs[i].exp_mstatus);
        end

        // Reset must beat a simultaneous trap, mret and write.
        @(negedge clk);
        idle();
        reset       = 1'b1;
        exception_i = 1'b1;
        mepc_i      = 32'h5554;
        mcause_i    = 32'h9;
        mtval_i     = 32'h77;
        mret_i      = 1'b1;
        csr_wbk_v_i = 1'b1;
        csr_adr_i   = 12'h305;
        csr_data_i  = 32'h44;
        @(posedge clk);
        #1;
        check("rtrap_mepc", mepc_q_o, 32'h0);
        check("rtrap_mstatus", mstatus_q_o, 32'h1800);
        check("rtrap_mtvec", mtvec_q_o, c_MT);
        rd_check("rtrap_mcause", 12'h342, 32'h0, 1'b0);
        rd_check("rtrap_mtval", 12'h343, 32'h0, 1'b0);
        rd_check("rtrap_mscratch", 12'h340, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        reset = 1'b0;

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 32'hFFFF_FFFE);
        wr(12'hB80, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        idle();
        rd_check("mcycleh_carry", 12'hB80, 32'h1, 1'b0);
        rd_check("mcycle_wrap", 12'hB00, 32'h0, 1'b0);

        // minstret was cleared by the reset above and nothing has retired.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle();
            retire_i = (k != 1 && k != 4);
        end
        @(negedge clk);
        idle();
        rd_check("minstret_cnt", 12'hB02, 32'h3, 1'b0);
        wr(12'hB02, 32'h10);
        retire_i = 1'b1;
        @(negedge clk);
        idle();
        rd_check("minstret_wr_wins", 12'hB02, 32'h10, 1'b0);
        rd_check("minstreth", 12'hB82, 32'h0, 1'b0);
`else
        @(negedge clk);
        idle();
        rd_check("nocnt_b00", 12'hB00, 32'h0, 1'b1);
        rd_check("nocnt_b82", 12'hB82, 32'h0, 1'b1);
        wr(12'hB00, 32'h1234);
        @(negedge clk);
        idle();
        rd_check("nocnt_b00_after_wr", 12'hB00, 32'h0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
